// File: rtl/alu_rs.sv
// ---------------------------------------------------------------------------
// alu_rs -- reservation station in front of the single-cycle integer ALU.
//
// Holds up to 2**RS_SIZE_WIDTH renamed ALU/branch/JALR micro-ops. Operands
// that are still being produced are tracked by ROB id and captured by
// snooping the ALU and load-store result buses. Each cycle the lowest-index
// ready entry is handed to the ALU through registered outputs.
//
// Ports:
//   clk_in, rst_in (sync, active high), rdy_in (global enable), flush
//   dispatch_*      : new entry from the dispatcher (qj/qk = awaited ROB ids)
//   alu_cdb_*       : ALU result broadcast
//   lsb_cdb_*       : load-store result broadcast
//   full            : every slot busy (combinational)
//   alu_en, alu_rob_id, alu_data_j, alu_data_k, alu_imm, alu_type
//                   : registered issue to the ALU
// ---------------------------------------------------------------------------
module alu_rs #(
  parameter int RS_SIZE_WIDTH = 3,
  parameter int RS_TYPE_WIDTH = 6
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     flush,

  input  logic                     dispatch_en,
  input  logic [RS_TYPE_WIDTH-1:0] dispatch_type,
  input  logic [31:0]              dispatch_rob_id,
  input  logic [31:0]              dispatch_imm,
  input  logic [31:0]              dispatch_vj,
  input  logic [31:0]              dispatch_vk,
  input  logic                     dispatch_qj_valid,
  input  logic                     dispatch_qk_valid,
  input  logic [31:0]              dispatch_qj,
  input  logic [31:0]              dispatch_qk,

  input  logic                     alu_cdb_rdy,
  input  logic [31:0]              alu_cdb_rob_id,
  input  logic [31:0]              alu_cdb_result,

  input  logic                     lsb_cdb_rdy,
  input  logic [31:0]              lsb_cdb_rob_id,
  input  logic [31:0]              lsb_cdb_result,

  output logic                     full,
  output logic                     alu_en,
  output logic [31:0]              alu_rob_id,
  output logic [31:0]              alu_data_j,
  output logic [31:0]              alu_data_k,
  output logic [31:0]              alu_imm,
  output logic [RS_TYPE_WIDTH-1:0] alu_type
);

  localparam int RS_SIZE = 1 << RS_SIZE_WIDTH;

  // Entry storage. Only the control bits are reset; payload fields are
  // always written before they can be observed.
  logic [RS_SIZE-1:0]       busy;
  logic [RS_SIZE-1:0]       qj_valid;
  logic [RS_SIZE-1:0]       qk_valid;
  logic [RS_TYPE_WIDTH-1:0] ent_type   [RS_SIZE];
  logic [31:0]              ent_rob_id [RS_SIZE];
  logic [31:0]              ent_imm    [RS_SIZE];
  logic [31:0]              ent_vj     [RS_SIZE];
  logic [31:0]              ent_vk     [RS_SIZE];
  logic [31:0]              ent_qj     [RS_SIZE];
  logic [31:0]              ent_qk     [RS_SIZE];

  logic [RS_SIZE-1:0]       ready;
  logic                     issue_found;
  logic [RS_SIZE_WIDTH-1:0] issue_idx;
  logic [RS_SIZE_WIDTH-1:0] free_idx;

  logic                     fwd_j_hit;
  logic                     fwd_k_hit;
  logic [31:0]              fwd_j_val;
  logic [31:0]              fwd_k_val;

  // An entry is ready once both operands are in hand. full looks only at
  // the pre-edge busy bits, so a slot freed by this cycle's issue cannot be
  // refilled until the next cycle.
  assign ready = busy & ~qj_valid & ~qk_valid;
  assign full  = &busy;

  // Lowest-index priority encoders for the issue slot and the free slot.
  // Scanning downward lets the last hit (the lowest index) win.
  always_comb begin
    issue_found = 1'b0;
    issue_idx   = '0;
    free_idx    = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready[i]) begin
        issue_found = 1'b1;
        issue_idx   = RS_SIZE_WIDTH'(i);
      end
      if (!busy[i]) begin
        free_idx = RS_SIZE_WIDTH'(i);
      end
    end
  end

  // Dispatch-time forwarding: an operand whose producer broadcasts in the
  // same cycle as the dispatch is captured directly, so the entry does not
  // miss the broadcast. The ALU bus is consulted before the load bus.
  always_comb begin
    fwd_j_hit = 1'b0;
    fwd_j_val = dispatch_vj;
    if (dispatch_qj_valid) begin
      if (alu_cdb_rdy && alu_cdb_rob_id == dispatch_qj) begin
        fwd_j_hit = 1'b1;
        fwd_j_val = alu_cdb_result;
      end else if (lsb_cdb_rdy && lsb_cdb_rob_id == dispatch_qj) begin
        fwd_j_hit = 1'b1;
        fwd_j_val = lsb_cdb_result;
      end
    end

    fwd_k_hit = 1'b0;
    fwd_k_val = dispatch_vk;
    if (dispatch_qk_valid) begin
      if (alu_cdb_rdy && alu_cdb_rob_id == dispatch_qk) begin
        fwd_k_hit = 1'b1;
        fwd_k_val = alu_cdb_result;
      end else if (lsb_cdb_rdy && lsb_cdb_rob_id == dispatch_qk) begin
        fwd_k_hit = 1'b1;
        fwd_k_val = lsb_cdb_result;
      end
    end
  end

  // Main state update: issue, snoop and dispatch all happen in one cycle.
  // Issue only ever touches a ready slot and dispatch only a non-busy slot,
  // so the two busy updates never target the same index, and snooping only
  // touches busy entries so it never collides with the dispatch write.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy       <= '0;
      qj_valid   <= '0;
      qk_valid   <= '0;
      alu_en     <= 1'b0;
      alu_rob_id <= '0;
      alu_data_j <= '0;
      alu_data_k <= '0;
      alu_imm    <= '0;
      alu_type   <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        busy   <= '0;
        alu_en <= 1'b0;
      end else begin
        // Issue: the data outputs keep their last values on idle cycles.
        if (issue_found) begin
          alu_en          <= 1'b1;
          alu_rob_id      <= ent_rob_id[issue_idx];
          alu_data_j      <= ent_vj[issue_idx];
          alu_data_k      <= ent_vk[issue_idx];
          alu_imm         <= ent_imm[issue_idx];
          alu_type        <= ent_type[issue_idx];
          busy[issue_idx] <= 1'b0;
        end else begin
          alu_en <= 1'b0;
        end

        // Snoop: j and k resolve independently, possibly in the same cycle.
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy[i] && qj_valid[i]) begin
            if (alu_cdb_rdy && alu_cdb_rob_id == ent_qj[i]) begin
              ent_vj[i]   <= alu_cdb_result;
              qj_valid[i] <= 1'b0;
            end else if (lsb_cdb_rdy && lsb_cdb_rob_id == ent_qj[i]) begin
              ent_vj[i]   <= lsb_cdb_result;
              qj_valid[i] <= 1'b0;
            end
          end
          if (busy[i] && qk_valid[i]) begin
            if (alu_cdb_rdy && alu_cdb_rob_id == ent_qk[i]) begin
              ent_vk[i]   <= alu_cdb_result;
              qk_valid[i] <= 1'b0;
            end else if (lsb_cdb_rdy && lsb_cdb_rob_id == ent_qk[i]) begin
              ent_vk[i]   <= lsb_cdb_result;
              qk_valid[i] <= 1'b0;
            end
          end
        end

        // Dispatch into the lowest free slot; a dispatch while full is dropped.
        if (dispatch_en && !full) begin
          busy[free_idx]       <= 1'b1;
          ent_type[free_idx]   <= dispatch_type;
          ent_rob_id[free_idx] <= dispatch_rob_id;
          ent_imm[free_idx]    <= dispatch_imm;
          ent_vj[free_idx]     <= fwd_j_val;
          ent_vk[free_idx]     <= fwd_k_val;
          ent_qj[free_idx]     <= dispatch_qj;
          ent_qk[free_idx]     <= dispatch_qk;
          qj_valid[free_idx]   <= dispatch_qj_valid && !fwd_j_hit;
          qk_valid[free_idx]   <= dispatch_qk_valid && !fwd_k_hit;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// ---------------------------------------------------------------------------
// tb_alu_rs -- self-checking bench for alu_rs.
//
// A behavioural model of the reservation station (a table of pending ops)
// is stepped alongside the DUT every clock; all outputs are compared one
// time unit after each rising edge. Directed scenarios come first, then a
// randomized run.
// ---------------------------------------------------------------------------
module tb_alu_rs;

  localparam int NE = 8;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        flush;
  logic        dispatch_en;
  logic [5:0]  dispatch_type;
  logic [31:0] dispatch_rob_id;
  logic [31:0] dispatch_imm;
  logic [31:0] dispatch_vj;
  logic [31:0] dispatch_vk;
  logic        dispatch_qj_valid;
  logic        dispatch_qk_valid;
  logic [31:0] dispatch_qj;
  logic [31:0] dispatch_qk;
  logic        alu_cdb_rdy;
  logic [31:0] alu_cdb_rob_id;
  logic [31:0] alu_cdb_result;
  logic        lsb_cdb_rdy;
  logic [31:0] lsb_cdb_rob_id;
  logic [31:0] lsb_cdb_result;
  logic        full;
  logic        alu_en;
  logic [31:0] alu_rob_id;
  logic [31:0] alu_data_j;
  logic [31:0] alu_data_k;
  logic [31:0] alu_imm;
  logic [5:0]  alu_type;

  alu_rs #(.RS_SIZE_WIDTH(3), .RS_TYPE_WIDTH(6)) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .rdy_in            (rdy_in),
    .flush             (flush),
    .dispatch_en       (dispatch_en),
    .dispatch_type     (dispatch_type),
    .dispatch_rob_id   (dispatch_rob_id),
    .dispatch_imm      (dispatch_imm),
    .dispatch_vj       (dispatch_vj),
    .dispatch_vk       (dispatch_vk),
    .dispatch_qj_valid (dispatch_qj_valid),
    .dispatch_qk_valid (dispatch_qk_valid),
    .dispatch_qj       (dispatch_qj),
    .dispatch_qk       (dispatch_qk),
    .alu_cdb_rdy       (alu_cdb_rdy),
    .alu_cdb_rob_id    (alu_cdb_rob_id),
    .alu_cdb_result    (alu_cdb_result),
    .lsb_cdb_rdy       (lsb_cdb_rdy),
    .lsb_cdb_rob_id    (lsb_cdb_rob_id),
    .lsb_cdb_result    (lsb_cdb_result),
    .full              (full),
    .alu_en            (alu_en),
    .alu_rob_id        (alu_rob_id),
    .alu_data_j        (alu_data_j),
    .alu_data_k        (alu_data_k),
    .alu_imm           (alu_imm),
    .alu_type          (alu_type)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: one record per slot plus the expected ALU outputs.
  typedef struct {
    bit          busy;
    logic [5:0]  typ;
    logic [31:0] rob;
    logic [31:0] imm;
    logic [31:0] vj;
    logic [31:0] vk;
    bit          qjv;
    bit          qkv;
    logic [31:0] qj;
    logic [31:0] qk;
  } ent_t;

  ent_t        m [NE];
  bit          e_en;
  logic [31:0] e_rob, e_j, e_k, e_imm;
  logic [5:0]  e_type;

  int nVectors = 0;
  int nFail    = 0;

  // Look a ROB id up on the two result buses, ALU bus first.
  task automatic lookup(input logic [31:0] id, output bit hit, output logic [31:0] val);
    hit = 1'b0;
    val = '0;
    if (alu_cdb_rdy && alu_cdb_rob_id == id) begin
      hit = 1'b1;
      val = alu_cdb_result;
    end else if (lsb_cdb_rdy && lsb_cdb_rob_id == id) begin
      hit = 1'b1;
      val = lsb_cdb_result;
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic modelStep();
    ent_t        pre [NE];
    int          iss;
    int          fr;
    bit          hit;
    logic [31:0] val;
    if (rst_in) begin
      foreach (m[i]) begin
        m[i].busy = 0;
        m[i].qjv  = 0;
        m[i].qkv  = 0;
      end
      e_en = 0; e_rob = 0; e_j = 0; e_k = 0; e_imm = 0; e_type = 0;
      return;
    end
    if (!rdy_in) return;
    if (flush) begin
      foreach (m[i]) m[i].busy = 0;
      e_en = 0;
      return;
    end
    pre = m;
    iss = -1;
    fr  = -1;
    for (int i = 0; i < NE; i++) begin
      if (iss < 0 && pre[i].busy && !pre[i].qjv && !pre[i].qkv) iss = i;
      if (fr < 0 && !pre[i].busy) fr = i;
    end
    if (iss >= 0) begin
      e_en   = 1;
      e_rob  = pre[iss].rob;
      e_j    = pre[iss].vj;
      e_k    = pre[iss].vk;
      e_imm  = pre[iss].imm;
      e_type = pre[iss].typ;
      m[iss].busy = 0;
    end else begin
      e_en = 0;
    end
    for (int i = 0; i < NE; i++) begin
      if (pre[i].busy && pre[i].qjv) begin
        lookup(pre[i].qj, hit, val);
        if (hit) begin m[i].vj = val; m[i].qjv = 0; end
      end
      if (pre[i].busy && pre[i].qkv) begin
        lookup(pre[i].qk, hit, val);
        if (hit) begin m[i].vk = val; m[i].qkv = 0; end
      end
    end
    if (dispatch_en && fr >= 0) begin
      m[fr].busy = 1;
      m[fr].typ  = dispatch_type;
      m[fr].rob  = dispatch_rob_id;
      m[fr].imm  = dispatch_imm;
      m[fr].qj   = dispatch_qj;
      m[fr].qk   = dispatch_qk;
      m[fr].vj   = dispatch_vj;
      m[fr].vk   = dispatch_vk;
      m[fr].qjv  = dispatch_qj_valid;
      m[fr].qkv  = dispatch_qk_valid;
      if (dispatch_qj_valid) begin
        lookup(dispatch_qj, hit, val);
        if (hit) begin m[fr].vj = val; m[fr].qjv = 0; end
      end
      if (dispatch_qk_valid) begin
        lookup(dispatch_qk, hit, val);
        if (hit) begin m[fr].vk = val; m[fr].qkv = 0; end
      end
    end
  endtask

  function automatic bit modelFull();
    bit f = 1;
    foreach (m[i]) if (!m[i].busy) f = 0;
    return f;
  endfunction

  task automatic chk(input string tag, input string sig, input logic [31:0] obs, input logic [31:0] exp);
    nVectors++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("[TB] FAIL %s %s: observed %0h expected %0h", tag, sig, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    chk(tag, "alu_en",     32'(alu_en),     32'(e_en));
    chk(tag, "full",       32'(full),       32'(modelFull()));
    chk(tag, "alu_rob_id", alu_rob_id,      e_rob);
    chk(tag, "alu_data_j", alu_data_j,      e_j);
    chk(tag, "alu_data_k", alu_data_k,      e_k);
    chk(tag, "alu_imm",    alu_imm,         e_imm);
    chk(tag, "alu_type",   32'(alu_type),   32'(e_type));
  endtask

  task automatic idleInputs();
    rst_in = 0; rdy_in = 1; flush = 0;
    dispatch_en = 0; dispatch_type = 0; dispatch_rob_id = 0; dispatch_imm = 0;
    dispatch_vj = 0; dispatch_vk = 0;
    dispatch_qj_valid = 0; dispatch_qk_valid = 0; dispatch_qj = 0; dispatch_qk = 0;
    alu_cdb_rdy = 0; alu_cdb_rob_id = 0; alu_cdb_result = 0;
    lsb_cdb_rdy = 0; lsb_cdb_rob_id = 0; lsb_cdb_result = 0;
  endtask

  // One clock: model update, edge, compare, then inputs back to idle.
  task automatic applyStimulus(input string tag);
    modelStep();
    @(posedge clk_in);
    #1;
    checkOutput(tag);
    idleInputs();
  endtask

  task automatic setDispatch(input logic [5:0] t, input logic [31:0] rob, input logic [31:0] imm,
                             input logic [31:0] vj, input logic [31:0] vk,
                             input bit qjv, input logic [31:0] qj, input bit qkv, input logic [31:0] qk);
    dispatch_en = 1; dispatch_type = t; dispatch_rob_id = rob; dispatch_imm = imm;
    dispatch_vj = vj; dispatch_vk = vk;
    dispatch_qj_valid = qjv; dispatch_qj = qj; dispatch_qk_valid = qkv; dispatch_qk = qk;
  endtask

  task automatic aluBcast(input logic [31:0] id, input logic [31:0] val);
    alu_cdb_rdy = 1; alu_cdb_rob_id = id; alu_cdb_result = val;
  endtask

  task automatic lsbBcast(input logic [31:0] id, input logic [31:0] val);
    lsb_cdb_rdy = 1; lsb_cdb_rob_id = id; lsb_cdb_result = val;
  endtask

  initial begin
    idleInputs();

    // Reset.
    rst_in = 1; applyStimulus("reset0");
    rst_in = 1; applyStimulus("reset1");

    // Independent ADD: issued one edge after dispatch, then idle.
    setDispatch(6'd0, 32'd3, 32'd0, 32'd5, 32'd7, 0, 0, 0, 0);
    applyStimulus("add_disp");
    applyStimulus("add_issue");
    applyStimulus("add_idle");

    // j waits on rob 2, resolved by the ALU bus two cycles later.
    setDispatch(6'd1, 32'd4, 32'h44, 32'd0, 32'd1, 1, 32'd2, 0, 0);
    applyStimulus("depj_disp");
    applyStimulus("depj_wait");
    aluBcast(32'd2, 32'h10);
    applyStimulus("depj_bcast");
    applyStimulus("depj_issue");
    applyStimulus("depj_idle");

    // k forwarded from the load bus in the dispatch cycle.
    setDispatch(6'd2, 32'd5, 32'h55, 32'd9, 32'd0, 0, 0, 1, 32'd9);
    lsbBcast(32'd9, 32'hDEAD);
    applyStimulus("fwdk_disp");
    applyStimulus("fwdk_issue");
    applyStimulus("fwdk_idle");

    // Fill all eight slots with dependent ops, then try a ninth.
    for (int i = 0; i < NE; i++) begin
      setDispatch(6'(i), 32'(20 + i), 32'(i), 32'(i), 32'(i), 1, 32'(100 + i), 0, 0);
      applyStimulus("fill");
    end
    setDispatch(6'd9, 32'd50, 32'd0, 32'd1, 32'd2, 0, 0, 0, 0);
    applyStimulus("full_drop");
    applyStimulus("full_hold");
    aluBcast(32'd105, 32'h5555);
    applyStimulus("slot5_resolve");
    applyStimulus("slot5_issue");
    setDispatch(6'd10, 32'd60, 32'h60, 32'd6, 32'd6, 0, 0, 0, 0);
    applyStimulus("slot5_refill");
    applyStimulus("slot5_reissue");
    flush = 1; applyStimulus("flush_a");

    // Slots 1 and 6 become ready together; lowest index goes first.
    for (int i = 0; i < 7; i++) begin
      setDispatch(6'(i), 32'(30 + i), 32'(i), 32'(i), 32'(i), 1, 32'(200 + i), 0, 0);
      applyStimulus("prio_fill");
    end
    aluBcast(32'd201, 32'hA1);
    lsbBcast(32'd206, 32'hA6);
    applyStimulus("prio_resolve");
    applyStimulus("prio_slot1");
    applyStimulus("prio_slot6");
    applyStimulus("prio_idle");
    flush = 1; applyStimulus("flush_b");

    // Freeze with rdy_in low while alu_en is high, then flush four entries.
    for (int i = 0; i < 5; i++) begin
      setDispatch(6'(i), 32'(40 + i), 32'(i), 32'(i), 32'(i), 0, 0, 1, 32'(300 + i));
      applyStimulus("frz_fill");
    end
    aluBcast(32'd300, 32'hB0);
    lsbBcast(32'd301, 32'hB1);
    applyStimulus("frz_resolve");
    applyStimulus("frz_issue");
    for (int i = 0; i < 3; i++) begin
      rdy_in = 0;
      setDispatch(6'd7, 32'd77, 32'd0, 32'd0, 32'd0, 0, 0, 0, 0);
      aluBcast(32'd302, 32'hB2);
      applyStimulus("frz_hold");
    end
    flush = 1;
    setDispatch(6'd8, 32'd78, 32'd0, 32'd0, 32'd0, 0, 0, 0, 0);
    applyStimulus("frz_flush");
    aluBcast(32'd303, 32'hB3);
    lsbBcast(32'd304, 32'hB4);
    applyStimulus("post_flush0");
    applyStimulus("post_flush1");
    applyStimulus("post_flush2");

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      rdy_in = ($urandom_range(0, 7) != 0);
      flush  = ($urandom_range(0, 59) == 0);
      rst_in = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 1) == 1)
        setDispatch(6'($urandom), 32'($urandom_range(0, 63)), $urandom, $urandom, $urandom,
                    1'($urandom), 32'($urandom_range(0, 15)), 1'($urandom), 32'($urandom_range(0, 15)));
      if ($urandom_range(0, 1) == 1) aluBcast(32'($urandom_range(0, 15)), $urandom);
      if ($urandom_range(0, 1) == 1) begin
        lsbBcast(32'($urandom_range(0, 15)), $urandom);
        if (alu_cdb_rdy && lsb_cdb_rob_id == alu_cdb_rob_id) lsb_cdb_rob_id = alu_cdb_rob_id ^ 32'd1;
      end
      applyStimulus("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nFail);
    $finish;
  end

endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- Reservation station feeding the single-cycle integer ALU; sits between the dispatcher and the ALU.
- Holds up to 2^RS_SIZE_WIDTH renamed ALU/branch/JALR micro-ops and snoops the ALU and load-store result buses to resolve operand dependencies.
- Each cycle it issues the oldest-slot ready entry (lowest index) to the ALU as registered en/rob_id/data_j/data_k/imm/type, one op per cycle.

Parameters:
- RS_SIZE_WIDTH, 3, log2 of entry count (8 entries).
- RS_TYPE_WIDTH, 6, width of the type code passed through unchanged to the ALU.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  synchronous active-high reset
- rdy_in  input  1  global enable; low = hold all state
- flush  input  1  misprediction flush; discard all entries
- dispatch_en  input  1  write a new entry this cycle
- dispatch_type  input  RS_TYPE_WIDTH  op type code
- dispatch_rob_id  input  32  destination ROB id
- dispatch_imm  input  32  immediate
- dispatch_vj / dispatch_vk  input  32 each  operand values when no dependency
- dispatch_qj_valid / dispatch_qk_valid  input  1 each  operand waits on a ROB id
- dispatch_qj / dispatch_qk  input  32 each  ROB id awaited
- alu_cdb_rdy, alu_cdb_rob_id[32], alu_cdb_result[32]  input  ALU broadcast
- lsb_cdb_rdy, lsb_cdb_rob_id[32], lsb_cdb_result[32]  input  load broadcast
- full  output  1  no free entry (combinational from busy bits)
- alu_en  output  1  issue valid (registered)
- alu_rob_id, alu_data_j, alu_data_k, alu_imm  output  32 each  issued entry fields (registered)
- alu_type  output  RS_TYPE_WIDTH  issued type (registered)

Behaviour:
- Entry state: busy, type, rob_id, imm, vj, vk, qj_valid, qj, qk_valid, qk. Ready = busy && !qj_valid && !qk_valid.
- Reset: all busy=0, all q*_valid=0; alu_en=0; alu_rob_id, alu_data_j, alu_data_k, alu_imm, alu_type = 0. Reset overrides rdy_in and flush.
- rdy_in=0: no state or output changes, including alu_en.
- flush (rdy_in=1): all busy cleared; alu_en<=0; dispatch and broadcasts in that cycle ignored.
- Dispatch: if dispatch_en && !full, write into the lowest-index non-busy entry.
  - Dispatch while full: dropped, no state change. The dispatcher must not do this.
- Dispatch-time forwarding: if a valid broadcast rob_id equals dispatch_qj (qj_valid=1) in the same cycle, store the broadcast result as vj and clear qj_valid. Same for k. The ALU bus is checked first, then LSB; both matching with equal id is illegal.
- Snoop: each cycle, every busy entry with q*_valid and q* == a valid broadcast rob_id captures that result and clears q*_valid. j and k are independent and may both resolve in one cycle.
- Issue: each cycle select the lowest-index entry that is ready at the start of the cycle.
  - Register its fields to the outputs, set alu_en<=1, clear its busy.
  - If none is ready, alu_en<=0; other outputs hold their previous values.
- An entry freed by issue in cycle N is not reusable by a dispatch in cycle N. full is evaluated on pre-edge state.
- Latency: dispatch with no deps at edge E → ready from E → issued at E+1 (alu_en high after E+1) → ALU result after E+2.
  - A dependency resolved by broadcast at edge E is issuable at E+1.
- Ordering is by slot index, not age. No fairness beyond lowest-index priority.
- Widths: all data paths are 32-bit, no arithmetic. The type code passes through untouched.

Test Plan:
- Reset, then dispatch ADD (type=0, rob 3, vj=5, vk=7, no deps) at edge 1 → alu_en=1, alu_rob_id=3, alu_data_j=5, alu_data_k=7 after edge 2; alu_en=0 after edge 3.
- Dispatch rob 4 with qj=2 pending, vk=1; broadcast alu_cdb rob 2 = 0x10 two cycles later → entry issues on the edge after the broadcast with alu_data_j=0x10; no earlier issue.
- Dispatch with qk=9 in the same cycle lsb_cdb_rdy broadcasts rob 9 = 0xDEAD → entry issues on the next edge with alu_data_k=0xDEAD (forwarding).
- Dispatch 8 dependent entries → full=1; a 9th dispatch is ignored. Resolve slot 5 → it issues, full drops; the next dispatch lands in slot 5.
- Two ready entries in slots 1 and 6 → slot 1 issues first, slot 6 on the following cycle.
- Hold rdy_in=0 for 3 cycles with a ready entry → outputs frozen. Then assert flush with 4 busy entries → all freed, alu_en=0, full=0, no later issue.
